// File: rtl/l2_line_cache.sv
// l2_line_cache: direct-mapped write-through L2 cache with multi-word lines, line fill from SDRAM,
// flush, hit/miss counters, and a combinational bypass for addresses at or above CACHE_LIMIT.
module l2_line_cache #(
    parameter int ADDR_BITS   = 24,
    parameter int DATA_BITS   = 32,
    parameter int INDEX_BITS  = 12,
    parameter int OFFSET_BITS = 2,
    parameter logic [ADDR_BITS-1:0] CACHE_LIMIT = 24'h800000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [ADDR_BITS-1:0] i_l2_addr,
    input  logic [DATA_BITS-1:0] i_l2_data,
    input  logic                 i_l2_we,
    input  logic                 i_l2_start,
    output logic [DATA_BITS-1:0] o_l2_q,
    output logic                 o_l2_done,
    input  logic                 i_flush,
    output logic [ADDR_BITS-1:0] o_sdc_addr,
    output logic [DATA_BITS-1:0] o_sdc_data,
    output logic                 o_sdc_we,
    output logic                 o_sdc_start,
    input  logic [DATA_BITS-1:0] i_sdc_q,
    input  logic                 i_sdc_done,
    output logic [31:0]          o_hit_count,
    output logic [31:0]          o_miss_count
);
    localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_ADDR = INDEX_BITS + OFFSET_BITS;

    typedef enum logic [3:0] {
        S_CLEAR, S_IDLE, S_LOOKUP, S_COMPARE, S_FILL_REQ, S_FILL_GAP, S_FILL_END, S_WRITE, S_DONE_HIGH
    } state_t;

    state_t r_state, w_next;

    logic [DATA_BITS-1:0] r_data_ram [2**LINE_ADDR];
    logic [TAG_BITS:0]    r_tag_ram  [2**INDEX_BITS];
    logic [DATA_BITS-1:0] r_data_q;
    logic [TAG_BITS:0]    r_tag_q;

    logic                  r_prev_start, r_prev_unc, r_pend, r_flush_pend;
    logic [ADDR_BITS-1:0]  r_req_addr, r_addr, r_sdc_addr;
    logic [DATA_BITS-1:0]  r_req_data, r_wdata, r_sdc_data, r_l2_q, r_fill_q;
    logic                  r_req_we, r_sdc_we, r_sdc_start, r_done;
    logic [INDEX_BITS-1:0] r_clr_idx;
    logic [OFFSET_BITS-1:0] r_k;
    logic [31:0]           r_hits, r_misses;

    logic                  w_cacheable, w_new, w_req, w_svc, w_svc_we, w_hit;
    logic [ADDR_BITS-1:0]  w_svc_addr;
    logic [DATA_BITS-1:0]  w_svc_data;
    logic [LINE_ADDR-1:0]  w_raddr;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [OFFSET_BITS-1:0] w_off;
    logic                  w_twe, w_dwe;
    logic [INDEX_BITS-1:0] w_twaddr;
    logic [TAG_BITS:0]     w_twdata;
    logic [LINE_ADDR-1:0]  w_dwaddr;
    logic [DATA_BITS-1:0]  w_dwdata;

    assign w_cacheable = i_l2_addr < CACHE_LIMIT;
    assign w_new       = w_cacheable & i_l2_start & (~r_prev_start | r_prev_unc);
    assign w_req       = w_new | (w_cacheable & r_pend);
    assign w_svc       = (r_state == S_IDLE) & ~r_flush_pend & w_req;
    // A fresh detection is served directly; otherwise the latched pending request is used.
    assign w_svc_addr  = w_new ? i_l2_addr : r_req_addr;
    assign w_svc_data  = w_new ? i_l2_data : r_req_data;
    assign w_svc_we    = w_new ? i_l2_we : r_req_we;
    assign w_raddr     = (r_state == S_IDLE) ? w_svc_addr[LINE_ADDR-1:0] : r_addr[LINE_ADDR-1:0];
    assign w_tag       = r_addr[ADDR_BITS-1:LINE_ADDR];
    assign w_idx       = r_addr[LINE_ADDR-1:OFFSET_BITS];
    assign w_off       = r_addr[OFFSET_BITS-1:0];
    assign w_hit       = r_tag_q[TAG_BITS] && (r_tag_q[TAG_BITS-1:0] == w_tag);

    assign o_sdc_addr   = w_cacheable ? r_sdc_addr : i_l2_addr;
    assign o_sdc_data   = w_cacheable ? r_sdc_data : i_l2_data;
    assign o_sdc_we     = w_cacheable ? r_sdc_we : i_l2_we;
    assign o_sdc_start  = w_cacheable ? r_sdc_start : i_l2_start;
    assign o_l2_q       = w_cacheable ? r_l2_q : i_sdc_q;
    assign o_l2_done    = w_cacheable ? r_done : i_sdc_done;
    assign o_hit_count  = r_hits;
    assign o_miss_count = r_misses;

    always_comb begin
        w_twe    = (r_state == S_CLEAR) | (r_state == S_FILL_END);
        w_twaddr = (r_state == S_CLEAR) ? r_clr_idx : w_idx;
        w_twdata = (r_state == S_CLEAR) ? '0 : {1'b1, w_tag};
        w_dwe    = i_sdc_done & ((r_state == S_FILL_REQ) | ((r_state == S_WRITE) & w_hit));
        w_dwaddr = (r_state == S_FILL_REQ) ? {w_idx, r_k} : r_addr[LINE_ADDR-1:0];
        w_dwdata = (r_state == S_FILL_REQ) ? i_sdc_q : r_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (w_twe) r_tag_ram[w_twaddr] <= w_twdata;
        if (w_dwe) r_data_ram[w_dwaddr] <= w_dwdata;
        r_tag_q  <= r_tag_ram[w_raddr[LINE_ADDR-1:OFFSET_BITS]];
        r_data_q <= r_data_ram[w_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_CLEAR;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR:     w_next = (&r_clr_idx) ? S_IDLE : S_CLEAR;
            S_IDLE:      w_next = r_flush_pend ? S_CLEAR : w_req ? (w_svc_we ? S_WRITE : S_LOOKUP) : S_IDLE;
            S_LOOKUP:    w_next = S_COMPARE;
            S_COMPARE:   w_next = w_hit ? S_DONE_HIGH : S_FILL_REQ;
            S_FILL_REQ:  w_next = i_sdc_done ? ((&r_k) ? S_FILL_END : S_FILL_GAP) : S_FILL_REQ;
            S_FILL_GAP:  w_next = S_FILL_REQ;
            S_FILL_END:  w_next = S_DONE_HIGH;
            S_WRITE:     w_next = i_sdc_done ? S_DONE_HIGH : S_WRITE;
            S_DONE_HIGH: w_next = S_IDLE;
            default:     w_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_start <= 1'b0;
            r_prev_unc   <= 1'b0;
            r_pend       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_req_addr   <= '0;
            r_req_data   <= '0;
            r_req_we     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_clr_idx    <= '0;
            r_k          <= '0;
            r_l2_q       <= '0;
            r_fill_q     <= '0;
            r_done       <= 1'b0;
            r_sdc_addr   <= '0;
            r_sdc_data   <= '0;
            r_sdc_we     <= 1'b0;
            r_sdc_start  <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            r_prev_start <= i_l2_start;
            r_prev_unc   <= ~w_cacheable;
            r_pend       <= w_svc ? 1'b0 : (w_new ? 1'b1 : r_pend);
            r_flush_pend <= i_flush | (r_flush_pend & (r_state != S_IDLE));
            r_clr_idx    <= (r_state == S_CLEAR) ? r_clr_idx + 1'b1 : '0;
            if (w_new) begin
                r_req_addr <= i_l2_addr;
                r_req_data <= i_l2_data;
                r_req_we   <= i_l2_we;
            end
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_svc) begin
                        r_addr  <= w_svc_addr;
                        r_wdata <= w_svc_data;
                        if (w_svc_we) begin
                            r_sdc_addr  <= w_svc_addr;
                            r_sdc_data  <= w_svc_data;
                            r_sdc_we    <= 1'b1;
                            r_sdc_start <= 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_l2_q <= r_data_q;
                        r_done <= 1'b1;
                        r_hits <= r_hits + 32'd1;
                    end else begin
                        r_misses    <= r_misses + 32'd1;
                        r_k         <= '0;
                        r_sdc_addr  <= {r_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        r_sdc_we    <= 1'b0;
                        r_sdc_start <= 1'b1;
                    end
                end
                S_FILL_REQ: begin
                    if (i_sdc_done) begin
                        r_sdc_start <= 1'b0;
                        r_k         <= r_k + 1'b1;
                        if (r_k == w_off) r_fill_q <= i_sdc_q;
                    end
                end
                S_FILL_GAP: begin
                    r_sdc_addr  <= {r_addr[ADDR_BITS-1:OFFSET_BITS], r_k};
                    r_sdc_start <= 1'b1;
                end
                S_FILL_END: begin
                    r_l2_q <= r_fill_q;
                    r_done <= 1'b1;
                end
                S_WRITE: begin
                    if (i_sdc_done) begin
                        r_sdc_start <= 1'b0;
                        r_sdc_we    <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_line_cache.sv
// tb_l2_line_cache: directed plus randomized checks of l2_line_cache against a line-map/memory model.
module tb_l2_line_cache;
    logic        clk, reset, l2_we, l2_start, flush, sdc_done;
    logic [23:0] l2_addr;
    logic [31:0] l2_data, sdc_q;
    logic [31:0] o_l2_q, o_sdc_data, o_hit_count, o_miss_count;
    logic [23:0] o_sdc_addr;
    logic        o_l2_done, o_sdc_we, o_sdc_start;

    int vectors = 0, errs = 0;
    int hits = 0, misses = 0;
    logic [31:0] mem [logic [23:0]];
    int          line_of [int];
    logic [24:0] sdc_log [$];

    l2_line_cache dut (
        .i_clk(clk), .i_reset(reset), .i_l2_addr(l2_addr), .i_l2_data(l2_data),
        .i_l2_we(l2_we), .i_l2_start(l2_start), .o_l2_q(o_l2_q), .o_l2_done(o_l2_done),
        .i_flush(flush), .o_sdc_addr(o_sdc_addr), .o_sdc_data(o_sdc_data), .o_sdc_we(o_sdc_we),
        .o_sdc_start(o_sdc_start), .i_sdc_q(sdc_q), .i_sdc_done(sdc_done),
        .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : ((32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM responder: random 1..3 cycle latency, one-cycle done pulse
    initial begin
        sdc_done = 1'b0;
        sdc_q = '0;
        forever begin
            @(negedge clk);
            sdc_done = 1'b0;
            if (o_sdc_start) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (o_sdc_start) begin
                    if (o_sdc_we) mem[o_sdc_addr] = o_sdc_data;
                    else sdc_q = rd(o_sdc_addr);
                    sdc_log.push_back({o_sdc_we, o_sdc_addr});
                    sdc_done = 1'b1;
                    @(negedge clk);
                    sdc_done = 1'b0;
                    for (int n = 0; n < 50 && o_sdc_start; n++) @(negedge clk);
                end
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!o_l2_done && n < 6000) begin
            tick();
            n++;
        end
        chk("done_seen", n < 6000, 1);
    endtask

    task automatic do_read(input logic [23:0] a, input bit held, output int n);
        bit exp_hit;
        int idx, ln;
        idx = int'(a[13:2]);
        ln = int'(a[23:2]);
        exp_hit = line_of.exists(idx) && line_of[idx] == ln;
        sdc_log.delete();
        l2_addr = a;
        l2_we = 1'b0;
        if (!held) l2_start = 1'b1;
        tick();
        l2_start = 1'b0;
        wait_done(n);
        if (exp_hit) chk("hit_latency", n, 2);
        chk("rd_q", o_l2_q, rd(a));
        tick();
        chk("done_hold", o_l2_done, 1);
        tick();
        chk("done_fall", o_l2_done, 0);
        if (exp_hit) hits++;
        else begin
            misses++;
            line_of[idx] = ln;
        end
        chk("hit_count", o_hit_count, hits);
        chk("miss_count", o_miss_count, misses);
        chk("sdc_words", sdc_log.size(), exp_hit ? 0 : 4);
        if (!exp_hit)
            for (int k = 0; k < 4 && k < sdc_log.size(); k++)
                chk("fill_addr", sdc_log[k], {1'b0, a[23:2], 2'(k)});
    endtask

    task automatic do_write(input logic [23:0] a, input logic [31:0] d);
        int n;
        sdc_log.delete();
        l2_addr = a;
        l2_data = d;
        l2_we = 1'b1;
        l2_start = 1'b1;
        tick();
        l2_start = 1'b0;
        l2_we = 1'b0;
        wait_done(n);
        chk("wr_sdc_n", sdc_log.size(), 1);
        if (sdc_log.size() > 0) chk("wr_sdc_addr", sdc_log[0], {1'b1, a});
        chk("wr_sdc_data", rd(a), d);
        tick();
        chk("wr_done_hold", o_l2_done, 1);
        tick();
        chk("wr_done_fall", o_l2_done, 0);
        chk("wr_hits", o_hit_count, hits);
        chk("wr_misses", o_miss_count, misses);
    endtask

    initial begin
        int n;
        logic [23:0] a;
        reset = 1'b1; l2_addr = '0; l2_data = '0; l2_we = 1'b0; l2_start = 1'b0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_done", o_l2_done, 0);
        chk("rst_start", o_sdc_start, 0);
        chk("rst_we", o_sdc_we, 0);
        chk("rst_addr", o_sdc_addr, 0);
        chk("rst_q", o_l2_q, 0);
        chk("rst_hits", o_hit_count, 0);
        chk("rst_misses", o_miss_count, 0);
        reset = 1'b0;

        do_read(24'h000104, 1'b0, n);
        do_read(24'h000106, 1'b0, n);
        do_write(24'h000105, 32'hDEADBEEF);
        do_read(24'h000105, 1'b0, n);
        do_write(24'h040000, 32'h12345678);
        do_read(24'h040000, 1'b0, n);
        do_read(24'h000104, 1'b0, n);
        do_read(24'h004104, 1'b0, n);
        do_read(24'h000104, 1'b0, n);

        sdc_log.delete();
        l2_addr = 24'h800010; l2_data = 32'hA5A5A5A5; l2_we = 1'b0; l2_start = 1'b1;
        #1;
        chk("pt_start", o_sdc_start, 1);
        chk("pt_addr", o_sdc_addr, 24'h800010);
        chk("pt_we", o_sdc_we, 0);
        chk("pt_data", o_sdc_data, 32'hA5A5A5A5);
        n = 0;
        while (!o_l2_done && n < 50) begin
            tick();
            n++;
        end
        chk("pt_done", o_l2_done, 1);
        chk("pt_q", o_l2_q, rd(24'h800010));
        chk("pt_log", sdc_log.size(), 1);
        chk("pt_hits", o_hit_count, hits);
        chk("pt_misses", o_miss_count, misses);
        do_read(24'h000106, 1'b1, n);

        for (int i = 0; i < 60; i++) begin
            a = {10'($urandom_range(0, 3)), 12'(12'h041 + 12'($urandom_range(0, 2))), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) do_write(a, $urandom);
            else do_read(a, 1'b0, n);
        end

        flush = 1'b1;
        tick();
        flush = 1'b0;
        line_of.delete();
        do_read(24'h000104, 1'b0, n);
        chk("flush_clear_time", n >= 4096, 1);

        l2_addr = 24'h00A3C8; l2_we = 1'b0; l2_start = 1'b1;
        tick();
        l2_start = 1'b0;
        n = 0;
        while (!o_sdc_start && n < 20) begin
            tick();
            n++;
        end
        chk("midfill_start", o_sdc_start, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("midfill_rst_start", o_sdc_start, 0);
        chk("midfill_rst_done", o_l2_done, 0);
        chk("midfill_rst_misses", o_miss_count, 0);
        reset = 1'b0;
        line_of.delete();
        hits = 0;
        misses = 0;
        do_read(24'h00A3C8, 1'b0, n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
